tick_arbiter: RTL and testbench

TICK_ARBITER -- requirements
Module: tick_arbiter

---
 rtl/tick_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_tick_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tick_arbiter
// Description : Round-robin arbiter for four requesters that share one
//               countdown timer clocked by a prescaled base tick. The winner
//               holds GRANT while its latched delay (in base ticks) counts
//               down, then gets a one-cycle DONE pulse.
//               Optional macro TICK_ARBITER_ABORT_EN adds the ABORT input,
//               which cancels a running countdown without a DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_arbiter #(
    parameter logic [27:0] DIVISOR = 28'd500000,
    parameter int          DELAY_W = 8
) (
    input  logic                   CLK_50,
    input  logic                   RESET_N,
    input  logic [3:0]             REQ,
    input  logic [4*DELAY_W-1:0]   DELAY,
`ifdef TICK_ARBITER_ABORT_EN
    input  logic                   ABORT,
`endif
    output logic [3:0]             GRANT,
    output logic [3:0]             DONE,
    output logic                   BUSY,
    output logic                   TICK
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Prescaler
    logic [27:0]        r_presc;
    logic [27:0]        w_presc_nxt;
    logic               r_tick;

    // Arbitration / countdown state
    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_remaining;
    logic [DELAY_W-1:0] w_remaining_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nxt;
    logic [3:0]         r_grant;
    logic [3:0]         w_grant_nxt;
    logic [3:0]         r_done;
    logic [3:0]         w_done_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    // Requester selection
    logic [1:0]         w_sel;
    logic               w_sel_valid;
    logic [1:0]         w_scan_idx;
    logic [DELAY_W-1:0] w_delay_arr [4];
    logic               w_abort;

    // Split the packed delay bus into one field per requester
    for (genvar gi = 0; gi < 4; gi++) begin : g_delay
        assign w_delay_arr[gi] = DELAY[gi*DELAY_W +: DELAY_W];
    end

`ifdef TICK_ARBITER_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // Free-running prescaler; TICK is registered so it lines up with the
    // cycle in which the counter sits at its terminal value
    assign w_presc_nxt = (r_presc == DIVISOR - 28'd1) ? 28'd0 : r_presc + 28'd1;

    // Prescaler counter and registered tick pulse
    always_ff @(posedge CLK_50) begin
        if (!RESET_N) begin
            r_presc <= 28'd0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == DIVISOR - 28'd1);
        end
    end

    // Round-robin scan: walk from farthest to nearest so the first set bit
    // after r_ptr (with wrap) is the one left standing
    always_comb begin
        w_sel       = 2'd0;
        w_sel_valid = 1'b0;
        w_scan_idx  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_scan_idx = r_ptr + 2'(k);
            if (REQ[w_scan_idx]) begin
                w_sel       = w_scan_idx;
                w_sel_valid = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; all outputs come from registers
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_grant_nxt     = r_grant;
        w_done_nxt      = 4'b0000;
        w_busy_nxt      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt     = S_COUNT;
                    w_owner_nxt     = w_sel;
                    w_remaining_nxt = w_delay_arr[w_sel];
                    w_grant_nxt     = 4'b0001 << w_sel;
                    w_busy_nxt      = 1'b1;
                end
            end
            S_COUNT: begin
                if (w_abort) begin
                    // Cancelled countdown: release without a DONE pulse
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = r_owner;
                end else if (r_remaining == '0) begin
                    // Zero delay finishes without waiting for a tick
                    w_state_nxt = S_DONE;
                    w_done_nxt  = r_grant;
                end else if (r_tick) begin
                    w_remaining_nxt = r_remaining - DELAY_W'(1);
                    if (r_remaining == DELAY_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = r_grant;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; ptr resets to 3 so requester 0 wins first
    always_ff @(posedge CLK_50) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_ptr       <= 2'd3;
            r_owner     <= 2'd0;
            r_grant     <= 4'b0000;
            r_done      <= 4'b0000;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign GRANT = r_grant;
    assign DONE  = r_done;
    assign BUSY  = r_busy;
    assign TICK  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_tick_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_arbiter
// Description : Self-checking bench for tick_arbiter (DIVISOR=4, DELAY_W=8).
//               Expected grants and DONE pulses are queued when stimulus is
//               driven and popped by a monitor as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_arbiter;

    localparam int DELAY_W = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] delay;
    logic        abort;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [3:0] exp_grant_q [$];
    logic [3:0] exp_done_q  [$];

    // Prescaler model: DIVISOR=4 so a 2-bit wrapping counter suffices
    logic [1:0] m_presc;
    logic       m_valid = 1'b0;
    logic [3:0] prev_grant = 4'b0000;

    tick_arbiter #(
        .DIVISOR (28'd4),
        .DELAY_W (DELAY_W)
    ) u_dut (
        .CLK_50  (clk),
        .RESET_N (rst_n),
        .REQ     (req),
        .DELAY   (delay),
`ifdef TICK_ARBITER_ABORT_EN
        .ABORT   (abort),
`endif
        .GRANT   (grant),
        .DONE    (done),
        .BUSY    (busy),
        .TICK    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Prescaler reference model
    always @(posedge clk) begin
        if (!rst_n) begin
            m_presc <= 2'd0;
            m_valid <= 1'b1;
        end else begin
            m_presc <= m_presc + 2'd1;
        end
    end

    // Monitor: TICK against model, one-hot rules, scoreboard for grants/dones
    always @(negedge clk) begin
        if (m_valid) begin
            check_value("tick", {31'd0, tick}, {31'd0, (m_presc == 2'd3)});
            check_value("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            check_value("done_onehot0", {31'd0, $onehot0(done)}, 32'd1);
            if (grant != 4'b0000 && prev_grant == 4'b0000) begin
                if (exp_grant_q.size() == 0) check_value("grant_unexpected", {28'd0, grant}, 32'd0);
                else check_value("grant_seq", {28'd0, grant}, {28'd0, exp_grant_q.pop_front()});
            end
            if (done != 4'b0000) begin
                if (exp_done_q.size() == 0) check_value("done_unexpected", {28'd0, done}, 32'd0);
                else check_value("done_seq", {28'd0, done}, {28'd0, exp_done_q.pop_front()});
            end
        end
        prev_grant <= grant;
    end

    task automatic wait_grant(input int budget, output logic [3:0] g);
        int i = 0;
        while (grant == 4'b0000 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (grant == 4'b0000) check_value("grant_timeout", 32'd1, 32'd0);
        g = grant;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy != 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (busy != 1'b0) check_value("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_grant_low(input int budget);
        int i = 0;
        while (grant != 4'b0000 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (grant != 4'b0000) check_value("release_timeout", 32'd1, 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        int cnt;
        int idle;
        int i;
        int seen;

        rst_n = 1'b0;
        req   = 4'b1111;
        delay = 32'd0;
        abort = 1'b0;

        // ---- Reset with all requests pending ----
        repeat (2) @(negedge clk);
        check_value("rst_grant", {28'd0, grant}, 32'd0);
        check_value("rst_done",  {28'd0, done},  32'd0);
        check_value("rst_busy",  {31'd0, busy},  32'd0);
        check_value("rst_tick",  {31'd0, tick},  32'd0);
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0001);
        rst_n = 1'b1;
        wait_grant(10, g);
        check_value("rst_first_grant", {28'd0, g}, 32'h1);
        req = 4'b0000;
        wait_idle(20);
        @(negedge clk);

        // ---- Requester 0, delay 3: DONE after the third counted tick ----
        delay[7:0] = 8'd3;
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0001);
        req = 4'b0001;
        @(negedge clk);
        check_value("lat_grant", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        cnt = 0;
        i = 0;
        while (cnt < 3 && i < 40) begin
            if (m_presc == 2'd3) cnt++;
            @(negedge clk);
            i++;
            if (cnt == 3) begin
                check_value("d3_done", {28'd0, done}, 32'h1);
                check_value("d3_grant_held", {28'd0, grant}, 32'h1);
            end else begin
                check_value("d3_quiet", {28'd0, done}, 32'h0);
            end
        end
        if (cnt < 3) check_value("d3_timeout", 32'd1, 32'd0);
        @(negedge clk);
        check_value("d3_busy_low", {31'd0, busy}, 32'd0);
        check_value("d3_grant_low", {28'd0, grant}, 32'd0);

        // ---- Round robin with all requests held, delay 1 each ----
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        delay = {8'd1, 8'd1, 8'd1, 8'd1};
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        exp_grant_q.push_back(4'b0100);
        exp_grant_q.push_back(4'b1000);
        exp_grant_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0001);
        exp_done_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0100);
        exp_done_q.push_back(4'b1000);
        exp_done_q.push_back(4'b0001);
        req = 4'b1111;
        wait_grant(10, g);
        for (int n = 1; n < 5; n++) begin
            wait_grant_low(20);
            idle = 0;
            while (grant == 4'b0000 && idle < 20) begin
                idle++;
                @(negedge clk);
            end
            check_value("rr_gap", idle, 32'd1);
        end
        req = 4'b0000;
        wait_idle(20);
        repeat (4) @(negedge clk);
        check_value("rr_stays_idle", {31'd0, busy}, 32'd0);

        // ---- Zero delay: DONE in the cycle after the grant, any tick phase ----
        delay = 32'd0;
        for (int ph = 0; ph < 4; ph++) begin
            exp_grant_q.push_back(4'b0100);
            exp_done_q.push_back(4'b0100);
            repeat (ph + 1) @(negedge clk);
            req = 4'b0100;
            @(negedge clk);
            check_value("z_grant", {28'd0, grant}, 32'h4);
            check_value("z_count", {28'd0, done},  32'h0);
            req = 4'b0000;
            @(negedge clk);
            check_value("z_done", {28'd0, done}, 32'h4);
            wait_idle(10);
        end

        // ---- Reset during COUNT for requester 1 ----
        delay[15:8] = 8'd6;
        exp_grant_q.push_back(4'b0010);
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        check_value("mr_grant", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_value("mr_grant_drop", {28'd0, grant}, 32'h0);
        check_value("mr_busy_drop",  {31'd0, busy},  32'h0);
        check_value("mr_no_done",    {28'd0, done},  32'h0);
        rst_n = 1'b1;
        i = 0;
        while (tick == 1'b0 && i < 10) begin
            @(negedge clk);
            i++;
        end
        check_value("mr_presc_restart", i, 32'd3);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done != 4'b0000) seen++;
        end
        check_value("mr_no_late_done", seen, 32'd0);

`ifdef TICK_ARBITER_ABORT_EN
        // ---- Abort during COUNT for requester 0 ----
        delay = {8'd0, 8'd0, 8'd0, 8'd5};
        exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        exp_done_q.push_back(4'b0010);
        req = 4'b0011;
        wait_grant(10, g);
        check_value("ab_first", {28'd0, g}, 32'h1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_value("ab_grant_drop", {28'd0, grant}, 32'h0);
        check_value("ab_no_done",    {28'd0, done},  32'h0);
        wait_grant(10, g);
        check_value("ab_next", {28'd0, g}, 32'h2);
        req = 4'b0000;
        wait_idle(20);
        repeat (2) @(negedge clk);
`endif

        check_value("grant_q_empty", exp_grant_q.size(), 32'd0);
        check_value("done_q_empty",  exp_done_q.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
